// File: rtl/uart_pkg.sv
// Shared definitions for the UART boot loader: receiver state encoding and default baud divisor.
package uart_pkg;

    // 50 MHz system clock at 115200 baud.
    localparam int unsigned DefaultClksPerBit = 434;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, framed byte and error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       byte_stb_o,
    output logic [7:0] byte_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

    logic            sync1_q, sync2_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, frame_err_q;
    logic            byte_stb, stop_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_stb  = 1'b0;
        stop_err  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!sync2_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    // A line that is high again by mid start bit was only a glitch.
                    state_d   = sync2_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (sync2_q) begin
                        byte_stb = 1'b1;
                    end else begin
                        stop_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        rx_data_d = byte_stb ? shift_q : rx_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rxd_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= byte_stb;
            frame_err_q <= stop_err;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    // Raw strobe lets the loader register its write in step with rx_valid.
    assign byte_stb_o  = byte_stb;
    assign byte_o      = shift_q;

endmodule

// File: rtl/uart_loader.sv
// Boot loader: packs received UART bytes big-endian into 32-bit words and writes them to
// instruction memory, holding the CPU in reset until WORDS words have been written.
module uart_loader
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned WORDS        = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        frame_err
);

    localparam logic [7:0] LastAddr = 8'(WORDS - 1);

    logic        byte_stb;
    logic [7:0]  byte_data;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic        wr_en_q, wr_en_d;
    logic        done_q, done_d;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk),
        .rst_ni     (reset),
        .rxd_i      (rxd),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err),
        .byte_stb_o (byte_stb),
        .byte_o     (byte_data)
    );

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        done_d     = done_q;
        if (byte_stb) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            wr_data_d  = {wr_data_q[23:0], byte_data};
            wr_en_d    = (byte_cnt_q == 2'd3) && !done_q;
        end
        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + 8'd1;
            if (wr_addr_q == LastAddr) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_q <= '0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign cpu_hold = !done_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with CLKS_PER_BIT = 4 and WORDS = 2.
module tb_uart_loader;

    localparam int unsigned CPB   = 4;
    localparam int unsigned NWORD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        frame_err;

    int tests = 0;
    int fails = 0;

    uart_loader #(
        .CLKS_PER_BIT(CPB),
        .WORDS       (NWORD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    int          rxv_cnt = 0, wre_cnt = 0, fe_cnt = 0, viol = 0;
    logic [31:0] wlog_data [16];
    logic [7:0]  wlog_addr [16];
    logic        done_at [16];
    logic        done_after [16];
    logic        hold_after [16];
    logic        prev_rxv = 1'b0, prev_wre = 1'b0, prev_fe = 1'b0;

    always @(negedge clk) begin
        if ((prev_rxv && rx_valid) || (prev_wre && wr_en) || (prev_fe && frame_err)) viol++;
        if (prev_wre && wre_cnt > 0 && wre_cnt <= 16) begin
            done_after[wre_cnt-1] = done;
            hold_after[wre_cnt-1] = cpu_hold;
        end
        if (rx_valid) rxv_cnt++;
        if (frame_err) fe_cnt++;
        if (wr_en) begin
            if (wre_cnt < 16) begin
                wlog_data[wre_cnt] = wr_data;
                wlog_addr[wre_cnt] = wr_addr;
                done_at[wre_cnt]   = done;
            end
            wre_cnt++;
        end
        prev_rxv = rx_valid;
        prev_wre = wr_en;
        prev_fe  = frame_err;
    end

    task automatic do_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        tests++; if (wr_addr !== 8'h00) begin fails++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
        tests++; if (wr_data !== 32'h0) begin fails++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        int rv0, we0;
        do_reset();
        rv0 = rxv_cnt; we0 = wre_cnt;
        send_byte(8'hA5, 1'b1);
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL single_rx_data: got %h want a5", rx_data); end
        tests++; if (rxv_cnt - rv0 != 1) begin fails++; $display("FAIL single_rx_valid_pulses: got %0d want 1", rxv_cnt - rv0); end
        tests++; if (wre_cnt - we0 != 0) begin fails++; $display("FAIL single_no_write: got %0d want 0", wre_cnt - we0); end
    endtask

    task automatic test_word();
        int we0;
        do_reset();
        we0 = wre_cnt;
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
        tests++; if (wre_cnt - we0 != 1) begin fails++; $display("FAIL word_wr_en_count: got %0d want 1", wre_cnt - we0); end
        tests++; if (wlog_data[we0] !== 32'h12345678) begin fails++; $display("FAIL word_wr_data: got %h want 12345678", wlog_data[we0]); end
        tests++; if (wlog_addr[we0] !== 8'h00) begin fails++; $display("FAIL word_wr_addr: got %h want 00", wlog_addr[we0]); end
        tests++; if (wr_addr !== 8'h01) begin fails++; $display("FAIL word_addr_incr: got %h want 01", wr_addr); end
        tests++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL word_not_done: got done=%b hold=%b want done=0 hold=1", done, cpu_hold); end
    endtask

    task automatic test_two_words();
        int we0, rv0;
        logic [7:0] bytes [12];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                  8'h01, 8'h02, 8'h03, 8'hC7};
        do_reset();
        we0 = wre_cnt; rv0 = rxv_cnt;
        for (int i = 0; i < 8; i++) send_byte(bytes[i], 1'b1);
        tests++; if (wre_cnt - we0 != 2) begin fails++; $display("FAIL two_wr_en_count: got %0d want 2", wre_cnt - we0); end
        tests++; if (wlog_addr[we0] !== 8'h00 || wlog_data[we0] !== 32'h12345678) begin fails++; $display("FAIL two_first_word: got %h@%h want 12345678@00", wlog_data[we0], wlog_addr[we0]); end
        tests++; if (wlog_addr[we0+1] !== 8'h01 || wlog_data[we0+1] !== 32'h9ABCDEF0) begin fails++; $display("FAIL two_second_word: got %h@%h want 9abcdef0@01", wlog_data[we0+1], wlog_addr[we0+1]); end
        tests++; if (done_at[we0+1] !== 1'b0) begin fails++; $display("FAIL two_done_early: got %b want 0", done_at[we0+1]); end
        tests++; if (done_after[we0+1] !== 1'b1 || hold_after[we0+1] !== 1'b0) begin fails++; $display("FAIL two_done_next_cycle: got done=%b hold=%b want done=1 hold=0", done_after[we0+1], hold_after[we0+1]); end
        for (int i = 8; i < 12; i++) send_byte(bytes[i], 1'b1);
        tests++; if (wre_cnt - we0 != 2) begin fails++; $display("FAIL after_done_no_write: got %0d want 2", wre_cnt - we0); end
        tests++; if (rxv_cnt - rv0 != 12) begin fails++; $display("FAIL after_done_rx_valid: got %0d want 12", rxv_cnt - rv0); end
        tests++; if (rx_data !== 8'hC7) begin fails++; $display("FAIL after_done_rx_data: got %h want c7", rx_data); end
        tests++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL done_sticky: got done=%b hold=%b want done=1 hold=0", done, cpu_hold); end
    endtask

    task automatic test_glitch();
        int rv0, fe0;
        do_reset();
        rv0 = rxv_cnt; fe0 = fe_cnt;
        rxd = 1'b0;
        @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tests++; if (rxv_cnt - rv0 != 0 || fe_cnt - fe0 != 0) begin fails++; $display("FAIL glitch_no_output: got rx_valid=%0d frame_err=%0d want 0/0", rxv_cnt - rv0, fe_cnt - fe0); end
        send_byte(8'h3C, 1'b1);
        tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL glitch_then_byte: got %h want 3c", rx_data); end
        tests++; if (rxv_cnt - rv0 != 1) begin fails++; $display("FAIL glitch_then_valid: got %0d want 1", rxv_cnt - rv0); end
    endtask

    task automatic test_frame_err();
        int rv0, fe0, we0;
        do_reset();
        rv0 = rxv_cnt; fe0 = fe_cnt; we0 = wre_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'h55, 1'b0);
        tests++; if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0); end
        tests++; if (rxv_cnt - rv0 != 1) begin fails++; $display("FAIL ferr_no_valid: got %0d want 1", rxv_cnt - rv0); end
        tests++; if (rx_data !== 8'h12) begin fails++; $display("FAIL ferr_rx_data_held: got %h want 12", rx_data); end
        send_byte(8'h34, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
        tests++; if (wre_cnt - we0 != 1 || wlog_data[we0] !== 32'h12345678) begin fails++; $display("FAIL ferr_byte_cnt_held: got %0d writes data %h want 1 write 12345678", wre_cnt - we0, wlog_data[we0]); end
    endtask

    task automatic test_reset_mid_frame();
        int we0, rv0;
        do_reset();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        rv0 = rxv_cnt;
        reset = 1'b0;
        #2;
        tests++; if (rx_data !== 8'h00 || wr_data !== 32'h0 || wr_addr !== 8'h00) begin fails++; $display("FAIL midrst_values: got rx_data=%h wr_data=%h wr_addr=%h want 0", rx_data, wr_data, wr_addr); end
        tests++; if (rx_valid !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL midrst_flags: got v=%b w=%b d=%b fe=%b h=%b want 0 0 0 0 1", rx_valid, wr_en, done, frame_err, cpu_hold); end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        we0 = wre_cnt;
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
        tests++; if (rxv_cnt - rv0 != 4) begin fails++; $display("FAIL midrst_no_pulse: got %0d want 4", rxv_cnt - rv0); end
        tests++; if (wre_cnt - we0 != 1 || wlog_data[we0] !== 32'h12345678 || wlog_addr[we0] !== 8'h00) begin fails++; $display("FAIL midrst_word: got %0d writes %h@%h want 1 write 12345678@00", wre_cnt - we0, wlog_data[we0], wlog_addr[we0]); end
    endtask

    task automatic test_pulse_widths();
        tests++; if (viol != 0) begin fails++; $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_word();
        test_two_words();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_pulse_widths();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434; clock cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter WORDS, default 256; number of 32-bit words loaded before completion.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 rxd  input  1  asynchronous UART serial line; idles high.
REQ-006 rx_data  output  8  last correctly framed byte; feeds the memory's rx_data port.
REQ-007 rx_valid  output  1  one-cycle pulse per correctly framed byte.
REQ-008 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-009 wr_addr  output  8  word address of the current write.
REQ-010 wr_data  output  32  assembled word; first received byte is bits 31:24 (big-endian).
REQ-011 cpu_hold  output  1  high until loading completes; gates the CPU's reset.
REQ-012 done  output  1  sticky high once WORDS words have been written.
REQ-013 frame_err  output  1  one-cycle pulse when a stop bit samples low.

Function
REQ-014 rxd passes through a 2-flop synchronizer; all bit decisions use the synchronized value.
REQ-015 Receiver FSM states are IDLE, START, DATA and STOP.
REQ-016 IDLE -> START on synchronized rxd == 0.
REQ-017 START: at count CLKS_PER_BIT/2 (integer division), rxd == 0 -> DATA with the bit counter cleared; rxd == 1 -> IDLE as a glitch, with no output.
REQ-018 DATA samples rxd every CLKS_PER_BIT cycles, LSB first; after 8 bits -> STOP.
REQ-019 STOP samples once after CLKS_PER_BIT cycles, then -> IDLE.
REQ-020 Stop bit 1 in STOP: rx_data updates and rx_valid pulses in the cycle after the sample.
REQ-021 Stop bit 0 in STOP: frame_err pulses, the byte is discarded, and rx_data and the byte counter are held.
REQ-022 Word assembly: a 2-bit byte counter shifts each valid byte into wr_data from the LSB end.
REQ-023 On the 4th valid byte, wr_en pulses in the same cycle as rx_valid, and wr_data holds the complete word.
REQ-024 wr_addr starts at 0 and increments the cycle after each wr_en.
REQ-025 On the WORDS-th write, done sets and cpu_hold clears in the following cycle; wr_addr wraps to 0 when WORDS = 256.
REQ-026 After done: bytes still update rx_data and pulse rx_valid; wr_en never asserts again; done stays set until reset.
REQ-027 A partial word pending at reset is discarded.
REQ-028 A glitch or frame error does not reset the byte counter.
REQ-029 wr_en, rx_valid and frame_err are never high for more than one consecutive cycle.

Reset
REQ-030 While reset == 0: FSM = IDLE; all counters = 0; rx_data = 0; wr_data = 0; wr_addr = 0; rx_valid, wr_en, done and frame_err = 0; cpu_hold = 1.
REQ-031 The synchronizer flops reset to 1 (line idle), so a low line at reset release is not treated as a start bit until after two clocks.
REQ-032 Reset asserted mid-frame aborts the frame with no output pulse.

Structure
REQ-033 A shared package uart_pkg holds the FSM state enum and the default-baud constant.
REQ-034 The serial receiver (synchronizer, FSM, rx_data, rx_valid, frame_err) is a sub-module uart_rx.
REQ-035 uart_loader instantiates uart_rx and adds the word assembler, the address counter and the done/hold logic.
REQ-036 The implementation fits 120-400 RTL lines.

Verification (CLKS_PER_BIT = 4, WORDS = 2)
REQ-037 Frame 0xA5 sent LSB first with a good stop bit -> rx_data = 0xA5 and one rx_valid pulse.
REQ-038 Bytes 12 34 56 78 -> one wr_en with wr_data = 0x12345678 and wr_addr = 0.
REQ-039 Bytes 12 34 56 78 9A BC DE F0 -> writes at addresses 0 and 1; the second word is 0x9ABCDEF0; done = 1 and cpu_hold = 0 one cycle after the second wr_en.
REQ-040 1-cycle low glitch on rxd, then byte 0x3C -> no output from the glitch; rx_data = 0x3C.
REQ-041 Byte 0x55 with stop bit 0 -> frame_err pulse; no rx_valid; the byte counter is unchanged.
REQ-042 reset driven to 0 in DATA after 2 bytes of a word -> all outputs at reset values; the next 4 bytes form the word at address 0.
